stream_rr_arbiter: RTL and testbench
====================================

STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 Parameter DATA_W, default 128, stream data width in bits.
REQ-002 Parameter CNT_W, default 32, beat-counter width in bits.
REQ-003 Port clk  input  1  single clock; all logic on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Ports s1i_valid in 1, s1i_rdy out 1, s1i_data in DATA_W  upstream stream 1.
REQ-006 Ports s2i_valid in 1, s2i_rdy out 1, s2i_data in DATA_W  upstream stream 2.
REQ-007 Ports so_valid out 1, so_rdy in 1, so_data out DATA_W, so_src out 1  merged stream to host; so_src 0 = stream 1, 1 = stream 2.
REQ-008 Ports cfg_wr in 1, cfg_addr in 2, cfg_wdata in 32, cfg_rdata out 32  register access on clk.

Function
REQ-009 Transfer on an input SHALL occur when sNi_valid and sNi_rdy are both high at a rising edge; on the output, when so_valid and so_rdy are both high.
REQ-010 The FSM SHALL have three states: IDLE, GRANT1, GRANT2.
REQ-011 sNi_rdy SHALL be high only in GRANTN, and only when the output register is empty or so_rdy is high.
REQ-012 The output register SHALL be one entry (data, src, full flag); an accepted beat SHALL appear on so_data/so_src with so_valid high in the cycle after the transfer (latency 1).
REQ-013 While so_valid is high and so_rdy is low, so_data and so_src SHALL hold stable.
REQ-014 From IDLE, the FSM SHALL go to GRANTN if only sNi_valid is high; if both are valid, it SHALL grant the source not in last_src; it SHALL stay in IDLE if neither is valid.
REQ-015 On entry to any GRANT state, burst_cnt SHALL be cleared to 0.
REQ-016 burst_cnt SHALL increment on each input transfer.
REQ-017 GRANTN SHALL be left when a transfer makes burst_cnt equal to burst_len, or when sNi_valid is low at the edge.
REQ-018 On leaving GRANTN, the FSM SHALL go to GRANT(other) if the other valid is high, else to IDLE, and SHALL set last_src to N.
REQ-019 burst_len (4 bits, register 0) SHALL have a reset value of 4; a written value of 0 SHALL behave as 1.
REQ-020 A burst_len write SHALL take effect for the next grant only.
REQ-021 cnt1 (register 1) and cnt2 (register 2) SHALL count input transfers per source, CNT_W bits, wrapping from all-ones to 0.
REQ-022 Any cfg write to register 1 or 2 SHALL clear that counter; when a clear coincides with an increment, the clear SHALL win (result 0).
REQ-023 Register 3 SHALL read as read-only status: {24'b0, out_full, last_src, state[1:0], burst_cnt[3:0]}; writes to it SHALL be ignored.
REQ-024 cfg_rdata SHALL be a combinational mux on cfg_addr (zero-extended to 32 bits).
REQ-025 A new beat and so_rdy in the same cycle SHALL replace the output register contents with no bubble (full throughput, 1 beat/cycle).

Reset
REQ-026 While rst_n is low, all state SHALL clear immediately: so_valid=0, so_data=0, so_src=0, s1i_rdy=s2i_rdy=0, state=IDLE, last_src=1 (so stream 1 wins the first tie), burst_cnt=0, cnt1=cnt2=0, burst_len=4.
REQ-027 A reset asserted mid-burst SHALL discard the held output beat; it SHALL not be re-presented.
REQ-028 After rst_n deasserts, the first grant SHALL be possible on the first rising edge.

Verification
REQ-029 Tie: burst_len=2, both streams always valid, so_rdy=1 -> output sources 1,1,2,2,1,1...; an IDLE cycle only at start; cnt1=cnt2 after an even number of bursts.
REQ-030 Backpressure: so_rdy low for 5 cycles while stream 1 sends 0xA5 -> so_data=0xA5 held stable, s1i_rdy=0 throughout, no loss or duplication when so_rdy returns.
REQ-031 Early end: burst_len=8, stream 1 drops valid after 3 beats, stream 2 valid -> switch to GRANT2 after beat 3; register 3 shows last_src=0.
REQ-032 Config edges: burst_len=0 -> alternation every beat; cnt1 preset near wrap via traffic at CNT_W=4 -> 15 then 0; register-1 write coinciding with a transfer -> cnt1 reads 0.
REQ-033 Reset mid-burst: rst_n low while so_valid=1 and so_rdy=0 -> so_valid=0 immediately; counters 0; burst_len reads 4.

Source files
------------

// File: rtl/stream_rr_arbiter_if.sv
// Bundles the two upstream streams, the merged output stream and the register port.
// Handshake semantics: a beat moves when valid and rdy are both high at a clk edge.
// slave = arbiter side, master = environment side (sources, sink, register host).
interface stream_rr_arbiter_if #(
  parameter int DATA_W = 128
);
  // upstream stream 1
  logic              s1i_valid;
  logic              s1i_rdy;
  logic [DATA_W-1:0] s1i_data;
  // upstream stream 2
  logic              s2i_valid;
  logic              s2i_rdy;
  logic [DATA_W-1:0] s2i_data;
  // merged stream; so_src 0 = stream 1, 1 = stream 2
  logic              so_valid;
  logic              so_rdy;
  logic [DATA_W-1:0] so_data;
  logic              so_src;
  // register access
  logic              cfg_wr;
  logic [1:0]        cfg_addr;
  logic [31:0]       cfg_wdata;
  logic [31:0]       cfg_rdata;

  modport slave (
    input  s1i_valid, s1i_data, output s1i_rdy,
    input  s2i_valid, s2i_data, output s2i_rdy,
    output so_valid, so_data, so_src, input so_rdy,
    input  cfg_wr, cfg_addr, cfg_wdata, output cfg_rdata
  );

  modport master (
    output s1i_valid, s1i_data, input s1i_rdy,
    output s2i_valid, s2i_data, input s2i_rdy,
    input  so_valid, so_data, so_src, output so_rdy,
    output cfg_wr, cfg_addr, cfg_wdata, input cfg_rdata
  );
endinterface

// File: rtl/stream_rr_arbiter.sv
// Round-robin burst arbiter merging two valid/rdy streams into one registered output.
// Latency: 1 cycle from input transfer to so_valid; full throughput of 1 beat/cycle.
// Backpressure: so_rdy low with the output register full drops the granted sNi_rdy.
// Ports: clk, rst_n (async active-low), bus (slave modport: s1i_*, s2i_*, so_*, cfg_*).
// Registers: 0 burst_len[3:0] (0 acts as 1), 1 cnt1, 2 cnt2, 3 status (read-only).
module stream_rr_arbiter #(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  stream_rr_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT1 = 2'd1,
    GRANT2 = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t            state;
  state_t            state_nxt;
  logic              s1_rdy;
  logic              s2_rdy;
  logic              xfer1;
  logic              xfer2;
  logic              out_free;
  logic              out_full;
  logic              out_src;
  logic [DATA_W-1:0] out_data;
  logic              last_src;
  logic [3:0]        burst_cnt;
  logic [3:0]        cur_len;
  logic [3:0]        burst_len;
  logic [3:0]        len_eff;
  logic              last_beat;
  logic              grant_entry;
  logic [CNT_W-1:0]  cnt1;
  logic [CNT_W-1:0]  cnt2;
  logic [31:0]       status;

  // The output slot can take a beat if empty or being drained this cycle.
  assign out_free  = !out_full || bus.so_rdy;
  assign xfer1     = bus.s1i_valid && s1_rdy;
  assign xfer2     = bus.s2i_valid && s2_rdy;
  assign len_eff   = (burst_len == 4'd0) ? 4'd1 : burst_len;
  // This transfer will be the last of the burst; cur_len never exceeds 15 so no wrap issue.
  assign last_beat = (burst_cnt + 4'd1) == cur_len;
  // Any change into a GRANT state, including GRANT1<->GRANT2 hand-over.
  assign grant_entry = (state_nxt != state) && (state_nxt != IDLE);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        // Tie goes to the source that did not hold the last grant.
        if (bus.s1i_valid && bus.s2i_valid) state_nxt = last_src ? GRANT1 : GRANT2;
        else if (bus.s1i_valid)             state_nxt = GRANT1;
        else if (bus.s2i_valid)             state_nxt = GRANT2;
      end
      GRANT1: begin
        if ((xfer1 && last_beat) || !bus.s1i_valid)
          state_nxt = bus.s2i_valid ? GRANT2 : IDLE;
      end
      GRANT2: begin
        if ((xfer2 && last_beat) || !bus.s2i_valid)
          state_nxt = bus.s1i_valid ? GRANT1 : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    s1_rdy = 1'b0;
    s2_rdy = 1'b0;
    case (state)
      GRANT1:  s1_rdy = out_free;
      GRANT2:  s2_rdy = out_free;
      default: ;
    endcase
  end

  assign bus.s1i_rdy = s1_rdy;
  assign bus.s2i_rdy = s2_rdy;

  // Burst bookkeeping. burst_len is sampled into cur_len only at grant entry, so a
  // register write mid-burst affects the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= 4'd0;
      cur_len   <= 4'd4;
      last_src  <= 1'b1;
    end else begin
      if (grant_entry) begin
        burst_cnt <= 4'd0;
        cur_len   <= len_eff;
      end else if (xfer1 || xfer2) begin
        burst_cnt <= burst_cnt + 4'd1;
      end
      if (state == GRANT1 && state_nxt != GRANT1) last_src <= 1'b0;
      if (state == GRANT2 && state_nxt != GRANT2) last_src <= 1'b1;
    end
  end

  // One-entry output register; load and drain in the same cycle gives no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_full <= 1'b0;
      out_src  <= 1'b0;
      out_data <= '0;
    end else if (xfer1 || xfer2) begin
      out_full <= 1'b1;
      out_src  <= xfer2;
      out_data <= xfer2 ? bus.s2i_data : bus.s1i_data;
    end else if (bus.so_rdy) begin
      out_full <= 1'b0;
    end
  end

  assign bus.so_valid = out_full;
  assign bus.so_data  = out_data;
  assign bus.so_src   = out_src;

  // Configuration and per-source counters; a clear beats a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_len <= 4'd4;
      cnt1      <= '0;
      cnt2      <= '0;
    end else begin
      if (bus.cfg_wr && bus.cfg_addr == 2'd0) burst_len <= bus.cfg_wdata[3:0];
      if (bus.cfg_wr && bus.cfg_addr == 2'd1) cnt1 <= '0;
      else if (xfer1)                         cnt1 <= cnt1 + CNT_ONE;
      if (bus.cfg_wr && bus.cfg_addr == 2'd2) cnt2 <= '0;
      else if (xfer2)                         cnt2 <= cnt2 + CNT_ONE;
    end
  end

  assign status = {24'b0, out_full, last_src, state, burst_cnt};

  always_comb begin
    bus.cfg_rdata = 32'd0;
    case (bus.cfg_addr)
      2'd0:    bus.cfg_rdata = {28'b0, burst_len};
      2'd1:    bus.cfg_rdata = 32'(cnt1);
      2'd2:    bus.cfg_rdata = 32'(cnt2);
      default: bus.cfg_rdata = status;
    endcase
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed testbench for stream_rr_arbiter (DATA_W=16, CNT_W=4 so counter wrap is reachable).
// Inputs change on the falling edge; outputs are sampled 1 ns later, away from the rising edge.
// Each scenario task carries its own inline comparisons against hand-computed values.
module tb_stream_rr_arbiter;
  localparam int DW = 16;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  stream_rr_arbiter_if #(.DATA_W(DW)) bus ();

  stream_rr_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic apply_reset;
    rst_n         = 1'b0;
    bus.s1i_valid = 1'b0;
    bus.s1i_data  = '0;
    bus.s2i_valid = 1'b0;
    bus.s2i_data  = '0;
    bus.so_rdy    = 1'b1;
    bus.cfg_wr    = 1'b0;
    bus.cfg_addr  = 2'd0;
    bus.cfg_wdata = 32'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.cfg_wr    = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_wdata = d;
    @(negedge clk);
    bus.cfg_wr    = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset;
    #1;
    total++; if (bus.so_valid !== 1'b0) begin bad++; $display("FAIL rst_so_valid got=%b want=0", bus.so_valid); end
    total++; if (bus.so_data !== 16'h0) begin bad++; $display("FAIL rst_so_data got=%h want=0", bus.so_data); end
    total++; if (bus.s1i_rdy !== 1'b0 || bus.s2i_rdy !== 1'b0) begin bad++; $display("FAIL rst_rdy got=%b%b want=00", bus.s1i_rdy, bus.s2i_rdy); end
    bus.cfg_addr = 2'd0; #1;
    total++; if (bus.cfg_rdata !== 32'd4) begin bad++; $display("FAIL rst_burst_len got=%0d want=4", bus.cfg_rdata); end
    bus.cfg_addr = 2'd3; #1;
    total++; if (bus.cfg_rdata !== 32'h40) begin bad++; $display("FAIL rst_status got=%h want=40", bus.cfg_rdata); end
    // Status is read-only; burst_len must not pick up the write either.
    cfg_write(2'd3, 32'hFF);
    bus.cfg_addr = 2'd3; #1;
    total++; if (bus.cfg_rdata !== 32'h40) begin bad++; $display("FAIL status_ro got=%h want=40", bus.cfg_rdata); end
    bus.cfg_addr = 2'd0; #1;
    total++; if (bus.cfg_rdata !== 32'd4) begin bad++; $display("FAIL status_ro_len got=%0d want=4", bus.cfg_rdata); end
  endtask

  task automatic test_tie;
    logic [7:0] exp_src;
    int n;
    exp_src = 8'b1100_1100;  // bit i = so_src of output i: 0,0,1,1,0,0,1,1
    n = 0;
    apply_reset;
    cfg_write(2'd0, 32'd2);
    @(negedge clk);
    bus.s1i_valid = 1'b1; bus.s1i_data = 16'h1111;
    bus.s2i_valid = 1'b1; bus.s2i_data = 16'h2222;
    bus.so_rdy = 1'b1;
    bus.cfg_addr = 2'd3;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 9) begin bus.s1i_valid = 1'b0; bus.s2i_valid = 1'b0; end
      #1;
      if (k >= 1) begin
        total++; if (bus.cfg_rdata[5:4] === 2'd0) begin bad++; $display("FAIL tie_no_idle k=%0d got state=0 want nonzero", k); end
      end
      if (bus.so_valid === 1'b1) begin
        if (n < 8) begin
          total++; if (bus.so_src !== exp_src[n]) begin bad++; $display("FAIL tie_src n=%0d got=%b want=%b", n, bus.so_src, exp_src[n]); end
          total++; if (bus.so_data !== (exp_src[n] ? 16'h2222 : 16'h1111)) begin bad++; $display("FAIL tie_data n=%0d got=%h", n, bus.so_data); end
        end
        n++;
      end
    end
    total++; if (n !== 8) begin bad++; $display("FAIL tie_count got=%0d want=8", n); end
    @(negedge clk);
    bus.cfg_addr = 2'd1; #1;
    total++; if (bus.cfg_rdata !== 32'd4) begin bad++; $display("FAIL tie_cnt1 got=%0d want=4", bus.cfg_rdata); end
    bus.cfg_addr = 2'd2; #1;
    total++; if (bus.cfg_rdata !== 32'd4) begin bad++; $display("FAIL tie_cnt2 got=%0d want=4", bus.cfg_rdata); end
  endtask

  task automatic test_backpressure;
    apply_reset;
    @(negedge clk);
    bus.s1i_valid = 1'b1; bus.s1i_data = 16'h00A5; bus.so_rdy = 1'b1;
    @(negedge clk); #1;
    total++; if (bus.s1i_rdy !== 1'b1) begin bad++; $display("FAIL bp_rdy_first got=%b want=1", bus.s1i_rdy); end
    @(negedge clk);
    bus.so_rdy = 1'b0; bus.s1i_data = 16'h005A;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      total++; if (bus.so_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid i=%0d got=%b want=1", i, bus.so_valid); end
      total++; if (bus.so_data !== 16'h00A5) begin bad++; $display("FAIL bp_hold_data i=%0d got=%h want=00a5", i, bus.so_data); end
      total++; if (bus.s1i_rdy !== 1'b0) begin bad++; $display("FAIL bp_rdy_low i=%0d got=%b want=0", i, bus.s1i_rdy); end
    end
    @(negedge clk);
    bus.so_rdy = 1'b1; #1;
    total++; if (bus.so_data !== 16'h00A5 || bus.s1i_rdy !== 1'b1) begin bad++; $display("FAIL bp_release got=%h/%b want=00a5/1", bus.so_data, bus.s1i_rdy); end
    @(negedge clk);
    bus.s1i_valid = 1'b0; #1;
    total++; if (bus.so_valid !== 1'b1 || bus.so_data !== 16'h005A) begin bad++; $display("FAIL bp_next got=%b/%h want=1/005a", bus.so_valid, bus.so_data); end
    @(negedge clk); #1;
    total++; if (bus.so_valid !== 1'b0) begin bad++; $display("FAIL bp_drained got=%b want=0", bus.so_valid); end
    bus.cfg_addr = 2'd1; #1;
    total++; if (bus.cfg_rdata !== 32'd2) begin bad++; $display("FAIL bp_cnt1 got=%0d want=2", bus.cfg_rdata); end
  endtask

  task automatic test_early_end;
    apply_reset;
    cfg_write(2'd0, 32'd8);
    @(negedge clk);
    bus.s1i_valid = 1'b1; bus.s1i_data = 16'h0101;
    bus.s2i_valid = 1'b1; bus.s2i_data = 16'h0202;
    bus.so_rdy = 1'b1;
    repeat (3) @(negedge clk);
    @(negedge clk);
    bus.s1i_valid = 1'b0; #1;
    total++; if (bus.so_valid !== 1'b1 || bus.so_src !== 1'b0) begin bad++; $display("FAIL early_beat3 got=%b/%b want=1/0", bus.so_valid, bus.so_src); end
    @(negedge clk);
    bus.cfg_addr = 2'd3; #1;
    total++; if (bus.cfg_rdata !== 32'h20) begin bad++; $display("FAIL early_status got=%h want=20", bus.cfg_rdata); end
    total++; if (bus.s2i_rdy !== 1'b1 || bus.s1i_rdy !== 1'b0) begin bad++; $display("FAIL early_rdy got=%b%b want=01", bus.s1i_rdy, bus.s2i_rdy); end
    @(negedge clk);
    bus.s2i_valid = 1'b0; #1;
    total++; if (bus.so_valid !== 1'b1 || bus.so_src !== 1'b1) begin bad++; $display("FAIL early_src2 got=%b/%b want=1/1", bus.so_valid, bus.so_src); end
    bus.cfg_addr = 2'd1; #1;
    total++; if (bus.cfg_rdata !== 32'd3) begin bad++; $display("FAIL early_cnt1 got=%0d want=3", bus.cfg_rdata); end
  endtask

  task automatic test_config_edges;
    logic [3:0] exp_src;
    int n;
    exp_src = 4'b1010;  // 0,1,0,1
    n = 0;
    apply_reset;
    cfg_write(2'd0, 32'd0);
    bus.cfg_addr = 2'd0; #1;
    total++; if (bus.cfg_rdata !== 32'd0) begin bad++; $display("FAIL len0_readback got=%0d want=0", bus.cfg_rdata); end
    @(negedge clk);
    bus.s1i_valid = 1'b1; bus.s1i_data = 16'h1111;
    bus.s2i_valid = 1'b1; bus.s2i_data = 16'h2222;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 5) begin bus.s1i_valid = 1'b0; bus.s2i_valid = 1'b0; end
      #1;
      if (bus.so_valid === 1'b1) begin
        if (n < 4) begin
          total++; if (bus.so_src !== exp_src[n]) begin bad++; $display("FAIL len0_src n=%0d got=%b want=%b", n, bus.so_src, exp_src[n]); end
        end
        n++;
      end
    end
    total++; if (n !== 4) begin bad++; $display("FAIL len0_count got=%0d want=4", n); end

    // Counter wrap at CNT_W=4, then a register-1 clear coinciding with a transfer.
    apply_reset;
    cfg_write(2'd0, 32'd15);
    @(negedge clk);
    bus.s1i_valid = 1'b1; bus.s1i_data = 16'h0C0C;
    bus.cfg_addr = 2'd1;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (k == 18) begin bus.cfg_wr = 1'b1; bus.cfg_wdata = 32'd0; end
      if (k == 19) begin bus.cfg_wr = 1'b0; bus.s1i_valid = 1'b0; end
      #1;
      if (k == 16 || k == 17) begin
        total++; if (bus.cfg_rdata !== 32'd15) begin bad++; $display("FAIL wrap_15 k=%0d got=%0d want=15", k, bus.cfg_rdata); end
      end
      if (k == 18) begin
        total++; if (bus.cfg_rdata !== 32'd0 || bus.s1i_rdy !== 1'b1) begin bad++; $display("FAIL wrap_0 got=%0d/%b want=0/1", bus.cfg_rdata, bus.s1i_rdy); end
      end
      if (k == 19) begin
        total++; if (bus.cfg_rdata !== 32'd0) begin bad++; $display("FAIL clear_wins got=%0d want=0", bus.cfg_rdata); end
      end
    end
  endtask

  task automatic test_reset_mid_burst;
    apply_reset;
    @(negedge clk);
    bus.s1i_valid = 1'b1; bus.s1i_data = 16'h0033; bus.so_rdy = 1'b1;
    @(negedge clk);
    bus.so_rdy = 1'b0;
    @(negedge clk); #1;
    total++; if (bus.so_valid !== 1'b1 || bus.so_data !== 16'h0033) begin bad++; $display("FAIL rmb_pre got=%b/%h want=1/0033", bus.so_valid, bus.so_data); end
    #1 rst_n = 1'b0;
    bus.s1i_data = 16'h0077;
    #1;
    total++; if (bus.so_valid !== 1'b0 || bus.so_data !== 16'h0) begin bad++; $display("FAIL rmb_out got=%b/%h want=0/0000", bus.so_valid, bus.so_data); end
    total++; if (bus.s1i_rdy !== 1'b0) begin bad++; $display("FAIL rmb_rdy got=%b want=0", bus.s1i_rdy); end
    bus.cfg_addr = 2'd1; #1;
    total++; if (bus.cfg_rdata !== 32'd0) begin bad++; $display("FAIL rmb_cnt1 got=%0d want=0", bus.cfg_rdata); end
    bus.cfg_addr = 2'd0; #1;
    total++; if (bus.cfg_rdata !== 32'd4) begin bad++; $display("FAIL rmb_len got=%0d want=4", bus.cfg_rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    total++; if (bus.so_valid !== 1'b0 || bus.s1i_rdy !== 1'b1) begin bad++; $display("FAIL rmb_first_grant got=%b/%b want=0/1", bus.so_valid, bus.s1i_rdy); end
    @(negedge clk);
    bus.s1i_valid = 1'b0; bus.so_rdy = 1'b1; #1;
    total++; if (bus.so_valid !== 1'b1 || bus.so_data !== 16'h0077) begin bad++; $display("FAIL rmb_new_beat got=%b/%h want=1/0077", bus.so_valid, bus.so_data); end
  endtask

  initial begin
    test_reset;
    test_tie;
    test_backpressure;
    test_early_end;
    test_config_edges;
    test_reset_mid_burst;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
